// File: rtl/dmem_arb.sv
// dmem_arb: shares one data memory between the CPU port (C) and a DMA/debug port (D).
// Zero-latency grants, locked bursts, bounded starvation; define DMEM_ARB_RR_EN for round-robin ties.
module dmem_arb #(
    parameter int DW      = 16,
    parameter int AW      = 8,
    parameter int MAXWAIT = 4,
    parameter int LOCKMAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic          c_lock,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wd,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wd,
    output logic          c_gnt,
    output logic          d_gnt,
    output logic [DW-1:0] c_rd,
    output logic [DW-1:0] d_rd,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wd,
    output logic          m_we,
    input  logic [DW-1:0] m_rd,
    output logic          busy,
    output logic          starve
);

    localparam int WCW = $clog2(MAXWAIT + 1);
    localparam int LCW = $clog2(LOCKMAX);
    localparam logic [WCW-1:0] WMAX  = WCW'(MAXWAIT);
    localparam logic [LCW-1:0] LLAST = LCW'(LOCKMAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCKC = 2'd1,
        LOCKD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic [WCW-1:0] wait_c_q, wait_c_d;
    logic [WCW-1:0] wait_d_q, wait_d_d;
    logic           last_d_q, last_d_d;   // D won the most recent IDLE arbitration
    logic           rel_q, rel_d;         // previous cycle was a forced lock release
    logic           rel_c_q, rel_c_d;     // the force-released owner was C
    logic           busy_q, busy_d;
    logic           starve_q, starve_d;
`ifdef DMEM_ARB_RR_EN
    logic           rr_d_q, rr_d_d;       // D wins the next plain conflict
`endif

    logic gc, gd, pick_d, c_sat, d_sat;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d  = state_q;
        lcnt_d   = lcnt_q;
        last_d_d = last_d_q;
        rel_d    = 1'b0;
        rel_c_d  = rel_c_q;
`ifdef DMEM_ARB_RR_EN
        rr_d_d   = rr_d_q;
`endif
        gc       = 1'b0;
        gd       = 1'b0;
        c_sat    = (wait_c_q == WMAX);
        d_sat    = (wait_d_q == WMAX);

        // Conflict resolution: forced release, then starvation, then the default policy.
        if (rel_q)               pick_d = rel_c_q;
        else if (c_sat && d_sat) pick_d = ~last_d_q;
        else if (d_sat)          pick_d = 1'b1;
        else if (c_sat)          pick_d = 1'b0;
        else begin
`ifdef DMEM_ARB_RR_EN
            pick_d = rr_d_q;
`else
            pick_d = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                if (c_req && d_req) begin
                    gd = pick_d;
                    gc = ~pick_d;
`ifdef DMEM_ARB_RR_EN
                    rr_d_d = ~pick_d;
`endif
                end else begin
                    gc = c_req;
                    gd = d_req;
                end
                if (gc || gd) last_d_d = gd;
                if (gc && c_lock) begin
                    state_d = LOCKC;
                    lcnt_d  = LCW'(1);
                end else if (gd && d_lock) begin
                    state_d = LOCKD;
                    lcnt_d  = LCW'(1);
                end
            end
            LOCKC: begin
                gc     = c_req;
                lcnt_d = lcnt_q + LCW'(1);
                if (!c_lock || !c_req || lcnt_q == LLAST) state_d = IDLE;
                if (lcnt_q == LLAST) begin
                    rel_d   = 1'b1;
                    rel_c_d = 1'b1;
                end
            end
            LOCKD: begin
                gd     = d_req;
                lcnt_d = lcnt_q + LCW'(1);
                if (!d_lock || !d_req || lcnt_q == LLAST) state_d = IDLE;
                if (lcnt_q == LLAST) begin
                    rel_d   = 1'b1;
                    rel_c_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!c_req || gc)  wait_c_d = '0;
        else if (c_sat)    wait_c_d = WMAX;
        else               wait_c_d = wait_c_q + WCW'(1);

        if (!d_req || gd)  wait_d_d = '0;
        else if (d_sat)    wait_d_d = WMAX;
        else               wait_d_d = wait_d_q + WCW'(1);

        busy_d   = (state_d != IDLE);
        starve_d = (wait_c_d == WMAX) || (wait_d_d == WMAX);
    end

    // Grants are forced low while reset is held so no write can slip into dmem.
    assign c_gnt  = gc & rst;
    assign d_gnt  = gd & rst;
    assign m_addr = c_gnt ? c_addr : (d_gnt ? d_addr : '0);
    assign m_wd   = c_gnt ? c_wd   : (d_gnt ? d_wd   : '0);
    assign m_we   = (c_gnt & c_we) | (d_gnt & d_we);
    assign c_rd   = m_rd;
    assign d_rd   = m_rd;
    assign busy   = busy_q;
    assign starve = starve_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lcnt_q   <= '0;
            wait_c_q <= '0;
            wait_d_q <= '0;
            last_d_q <= 1'b1;
            rel_q    <= 1'b0;
            rel_c_q  <= 1'b0;
            busy_q   <= 1'b0;
            starve_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_d_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lcnt_q   <= lcnt_d;
            wait_c_q <= wait_c_d;
            wait_d_q <= wait_d_d;
            last_d_q <= last_d_d;
            rel_q    <= rel_d;
            rel_c_q  <= rel_c_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
`ifdef DMEM_ARB_RR_EN
            rr_d_q   <= rr_d_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: table-driven per-cycle vectors plus hand-built lock/reset sequences for dmem_arb.
// A behavioural dmem (combinational read, clocked write) sits on the m_* bus.
module tb_dmem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_lock, d_req, d_we, d_lock;
    logic [7:0]  c_addr, d_addr, m_addr;
    logic [15:0] c_wd, d_wd, c_rd, d_rd, m_wd, m_rd;
    logic        c_gnt, d_gnt, m_we, busy, starve;

    int total = 0;
    int bad   = 0;
    int vid   = 0;

    logic [15:0] mem [256];

    typedef struct {
        logic        r;
        logic        cq, cw, cl;
        logic [7:0]  ca;
        logic [15:0] cwd;
        logic        dq, dw, dl;
        logic [7:0]  da;
        logic [15:0] dwd;
        logic        ecg, edg, ewe;
        logic [7:0]  ea;
        logic        eb, es, ck;
        logic [15:0] erd;
    } vec_t;

    vec_t tbl[$];

    dmem_arb #(.DW(16), .AW(8), .MAXWAIT(4), .LOCKMAX(8)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wd(c_wd),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wd(d_wd),
        .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rd(c_rd), .d_rd(d_rd),
        .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_rd(m_rd),
        .busy(busy), .starve(starve)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    end
    always @(posedge clk) if (m_we) mem[m_addr] <= m_wd;
    assign m_rd = mem[m_addr];

    function automatic vec_t mk(input logic r,
                                input logic cq, cw, cl, input logic [7:0] ca, input logic [15:0] cwd,
                                input logic dq, dw, dl, input logic [7:0] da, input logic [15:0] dwd,
                                input logic ecg, edg, ewe, input logic [7:0] ea,
                                input logic eb, es, ck, input logic [15:0] erd);
        vec_t v;
        v.r = r;  v.cq = cq; v.cw = cw; v.cl = cl; v.ca = ca; v.cwd = cwd;
        v.dq = dq; v.dw = dw; v.dl = dl; v.da = da; v.dwd = dwd;
        v.ecg = ecg; v.edg = edg; v.ewe = ewe; v.ea = ea;
        v.eb = eb; v.es = es; v.ck = ck; v.erd = erd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, vid, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then sample before the next rising edge.
    task automatic run(input vec_t v);
        @(negedge clk);
        rst = v.r;
        c_req = v.cq; c_we = v.cw; c_lock = v.cl; c_addr = v.ca; c_wd = v.cwd;
        d_req = v.dq; d_we = v.dw; d_lock = v.dl; d_addr = v.da; d_wd = v.dwd;
        #1;
        check("c_gnt",  32'(c_gnt),  32'(v.ecg));
        check("d_gnt",  32'(d_gnt),  32'(v.edg));
        check("m_we",   32'(m_we),   32'(v.ewe));
        check("m_addr", 32'(m_addr), 32'(v.ea));
        check("busy",   32'(busy),   32'(v.eb));
        check("starve", 32'(starve), 32'(v.es));
        if (v.ck) begin
            check("c_rd", 32'(c_rd), 32'(v.erd));
            check("d_rd", 32'(d_rd), 32'(v.erd));
        end
        vid++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout vec=%0d", vid);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_lock = 1'b0; c_addr = 8'h0; c_wd = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = 8'h0; d_wd = 16'h0;

        //                 r  cq cw cl ca     cwd       dq dw dl da     dwd       cg dg we ea     b  s  ck erd
        tbl.push_back(mk(0, 1, 1, 0, 8'h10, 16'h1234, 1, 0, 0, 8'h20, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 1, 1, 0, 8'h10, 16'h1234, 1, 0, 0, 8'h20, 16'h0000, 1, 0, 1, 8'h10, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h10, 16'h0000, 0, 1, 0, 8'h10, 0, 0, 1, 16'h1234));
        tbl.push_back(mk(1, 1, 0, 0, 8'h10, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h10, 0, 0, 1, 16'h1234));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 16'h0000, 1, 1, 0, 8'h22, 16'hBEEF, 0, 1, 1, 8'h22, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h22, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h22, 0, 0, 1, 16'hBEEF));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0));
`ifdef DMEM_ARB_RR_EN
        // Round-robin: held conflict alternates C,D,C,D with no starvation.
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 1, 0, 0, 8'h01, 16'h0, 1, 0, 0, 8'h02, 16'h0,
                             (k % 2) == 0, (k % 2) == 1, 0, ((k % 2) == 0) ? 8'h01 : 8'h02, 0, 0, 0, 16'h0));
`else
        // Fixed priority: C wins four times, D is force-granted on the fifth cycle.
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(1, 1, 0, 0, 8'h01, 16'h0, 1, 0, 0, 8'h02, 16'h0,
                             k != 4, k == 4, 0, (k == 4) ? 8'h02 : 8'h01, 0, k == 4, 0, 16'h0));
        // D drops req while waiting: its wait count clears, so it never reaches starvation.
        tbl.push_back(mk(1, 1, 0, 0, 8'h01, 16'h0, 1, 0, 0, 8'h02, 16'h0, 1, 0, 0, 8'h01, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h01, 16'h0, 1, 0, 0, 8'h02, 16'h0, 1, 0, 0, 8'h01, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h01, 16'h0, 0, 0, 0, 8'h02, 16'h0, 1, 0, 0, 8'h01, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h01, 16'h0, 1, 0, 0, 8'h02, 16'h0, 1, 0, 0, 8'h01, 0, 0, 0, 16'h0));
        tbl.push_back(mk(1, 1, 0, 0, 8'h01, 16'h0, 1, 0, 0, 8'h02, 16'h0, 1, 0, 0, 8'h01, 0, 0, 0, 16'h0));
`endif
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0));

        foreach (tbl[i]) run(tbl[i]);

        // D locked burst with C waiting from cycle 1: forced release after LOCKMAX grants.
        for (int k = 0; k < 9; k++)
            run(mk(1, k >= 1, 0, 0, 8'h43, 16'h0,
                   1, 1, 1, 8'(8'h40 + k), 16'(k),
                   k >= 8, k <= 7, k <= 7, (k <= 7) ? 8'(8'h40 + k) : 8'h43,
                   (k >= 1) && (k <= 7), (k >= 5) && (k <= 8), k >= 8, 16'h0003));
        run(mk(1, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0));

        // Reset in the middle of a D burst write: write suppressed, busy cleared.
        run(mk(1, 0, 0, 0, 8'h00, 16'h0, 1, 1, 1, 8'h60, 16'hAAAA, 0, 1, 1, 8'h60, 0, 0, 0, 16'h0));
        run(mk(1, 0, 0, 0, 8'h00, 16'h0, 1, 1, 1, 8'h61, 16'hBBBB, 0, 1, 1, 8'h61, 1, 0, 0, 16'h0));
        run(mk(0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 1, 8'h62, 16'hCCCC, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0));
        run(mk(1, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0,    0, 0, 0, 8'h00, 0, 0, 0, 16'h0));
        run(mk(1, 1, 0, 0, 8'h62, 16'h0, 0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h62, 0, 0, 1, 16'h0000));
        run(mk(1, 1, 0, 0, 8'h61, 16'h0, 0, 0, 0, 8'h00, 16'h0,    1, 0, 0, 8'h61, 0, 0, 1, 16'hBBBB));

        // C lock released by dropping c_lock; D is shut out while C owns the memory.
        run(mk(1, 1, 1, 1, 8'h70, 16'h0001, 0, 0, 0, 8'h00, 16'h0, 1, 0, 1, 8'h70, 0, 0, 0, 16'h0));
        run(mk(1, 1, 1, 1, 8'h71, 16'h0002, 1, 0, 0, 8'h72, 16'h0, 1, 0, 1, 8'h71, 1, 0, 0, 16'h0));
        run(mk(1, 1, 1, 0, 8'h72, 16'h0003, 1, 0, 0, 8'h72, 16'h0, 1, 0, 1, 8'h72, 1, 0, 0, 16'h0));
        run(mk(1, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 8'h72, 16'h0, 0, 1, 0, 8'h72, 0, 0, 1, 16'h0003));
        run(mk(1, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
